// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution and EX/MEM output register.
// Define SERIAL_SHIFT_EN for a 1-bit-per-cycle shifter (IDLE/SHIFT FSM) instead of the barrel shifter.
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_val,
    input  logic [31:0] id_rs2_val,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rd,
    input  logic [2:0]  id_funct3,
    input  logic        id_funct7,
    input  logic        id_alu_src,
    input  logic        id_branch,
    input  logic [1:0]  id_alu_op,
    input  logic        flush_in,
    output logic        stall_out,
    output logic        ex_valid,
    output logic [31:0] ex_alu_result,
    output logic [31:0] ex_rs2_val,
    output logic [4:0]  ex_rd,
    output logic        ex_branch_taken,
    output logic [31:0] ex_branch_target
);

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu_result;
    logic        w_branch_taken;
    logic [31:0] w_target;
    logic        w_accept;

    assign w_op_a   = id_rs1_val;
    assign w_op_b   = id_alu_src ? id_imm : id_rs2_val;
    assign w_shamt  = w_op_b[4:0];
    assign w_target = id_pc + id_imm;
    assign w_accept = id_valid && !stall_out && !flush_in;

    always_comb begin
        w_alu_result = w_op_a + w_op_b;
        case (id_alu_op)
            2'b00: w_alu_result = w_op_a + w_op_b;
            2'b01: w_alu_result = w_op_a - w_op_b;
            2'b11: w_alu_result = w_op_b;
            2'b10: begin
                case (id_funct3)
                    3'b000: w_alu_result = (id_funct7 && !id_alu_src) ? (w_op_a - w_op_b)
                                                                      : (w_op_a + w_op_b);
                    3'b001: w_alu_result = w_op_a << w_shamt;
                    3'b010: w_alu_result = {31'b0, $signed(w_op_a) < $signed(w_op_b)};
                    3'b011: w_alu_result = {31'b0, w_op_a < w_op_b};
                    3'b100: w_alu_result = w_op_a ^ w_op_b;
                    3'b101: w_alu_result = id_funct7 ? 32'($signed(w_op_a) >>> w_shamt)
                                                     : (w_op_a >> w_shamt);
                    3'b110: w_alu_result = w_op_a | w_op_b;
                    default: w_alu_result = w_op_a & w_op_b;
                endcase
            end
            default: w_alu_result = w_op_a + w_op_b;
        endcase
    end

    // Branches always compare the two register operands, never the immediate.
    always_comb begin
        w_branch_taken = 1'b0;
        if (id_branch) begin
            case (id_funct3)
                3'b000: w_branch_taken = (id_rs1_val == id_rs2_val);
                3'b001: w_branch_taken = (id_rs1_val != id_rs2_val);
                3'b100: w_branch_taken = ($signed(id_rs1_val) < $signed(id_rs2_val));
                3'b101: w_branch_taken = ($signed(id_rs1_val) >= $signed(id_rs2_val));
                3'b110: w_branch_taken = (id_rs1_val < id_rs2_val);
                3'b111: w_branch_taken = (id_rs1_val >= id_rs2_val);
                default: w_branch_taken = 1'b0;
            endcase
        end
    end

`ifdef SERIAL_SHIFT_EN

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t      r_state;
    logic [31:0] r_shift_val;
    logic [4:0]  r_shift_cnt;
    logic        r_shift_right;
    logic        r_shift_arith;
    logic [4:0]  r_pend_rd;
    logic [31:0] r_pend_rs2;
    logic        w_is_shift;
    logic        w_serial_start;
    logic [31:0] w_shift_next;

    assign stall_out      = (r_state == S_SHIFT);
    assign w_is_shift     = !id_branch && (id_alu_op == 2'b10) &&
                            ((id_funct3 == 3'b001) || (id_funct3 == 3'b101));
    assign w_serial_start = w_accept && w_is_shift && (w_shamt != 5'd0);
    assign w_shift_next   = !r_shift_right ? {r_shift_val[30:0], 1'b0}
                          : {r_shift_arith & r_shift_val[31], r_shift_val[31:1]};

    // A zero shift amount takes the ordinary single-cycle path through the barrel result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_shift_val      <= '0;
            r_shift_cnt      <= '0;
            r_shift_right    <= 1'b0;
            r_shift_arith    <= 1'b0;
            r_pend_rd        <= '0;
            r_pend_rs2       <= '0;
            ex_valid         <= 1'b0;
            ex_alu_result    <= '0;
            ex_rs2_val       <= '0;
            ex_rd            <= '0;
            ex_branch_taken  <= 1'b0;
            ex_branch_target <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush_in) begin
                        ex_valid        <= 1'b0;
                        ex_branch_taken <= 1'b0;
                    end else if (w_serial_start) begin
                        r_shift_val   <= w_op_a;
                        r_shift_cnt   <= w_shamt;
                        r_shift_right <= id_funct3[2];
                        r_shift_arith <= id_funct7;
                        r_pend_rd     <= id_rd;
                        r_pend_rs2    <= id_rs2_val;
                        ex_valid      <= 1'b0;
                        r_state       <= S_SHIFT;
                    end else if (w_accept) begin
                        ex_valid         <= 1'b1;
                        ex_alu_result    <= w_alu_result;
                        ex_rs2_val       <= id_rs2_val;
                        ex_rd            <= id_rd;
                        ex_branch_taken  <= w_branch_taken;
                        ex_branch_target <= w_target;
                    end else begin
                        ex_valid <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (flush_in) begin
                        r_shift_cnt     <= '0;
                        ex_valid        <= 1'b0;
                        ex_branch_taken <= 1'b0;
                        r_state         <= S_IDLE;
                    end else begin
                        r_shift_val <= w_shift_next;
                        r_shift_cnt <= r_shift_cnt - 5'd1;
                        if (r_shift_cnt == 5'd1) begin
                            ex_valid        <= 1'b1;
                            ex_alu_result   <= w_shift_next;
                            ex_rs2_val      <= r_pend_rs2;
                            ex_rd           <= r_pend_rd;
                            ex_branch_taken <= 1'b0;
                            r_state         <= S_IDLE;
                        end else begin
                            ex_valid <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`else

    assign stall_out = 1'b0;

    // Flush clears the taken flag; other bubbles only drop ex_valid and keep the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid         <= 1'b0;
            ex_alu_result    <= '0;
            ex_rs2_val       <= '0;
            ex_rd            <= '0;
            ex_branch_taken  <= 1'b0;
            ex_branch_target <= '0;
        end else if (flush_in) begin
            ex_valid        <= 1'b0;
            ex_branch_taken <= 1'b0;
        end else if (w_accept) begin
            ex_valid         <= 1'b1;
            ex_alu_result    <= w_alu_result;
            ex_rs2_val       <= id_rs2_val;
            ex_rd            <= id_rd;
            ex_branch_taken  <= w_branch_taken;
            ex_branch_target <= w_target;
        end else begin
            ex_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; shift latency expectations follow SERIAL_SHIFT_EN.
module tb_ex_stage;

`ifdef SERIAL_SHIFT_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_imm;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7;
    logic        id_alu_src;
    logic        id_branch;
    logic [1:0]  id_alu_op;
    logic        flush_in;
    logic        stall_out;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_val;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;

    int testCount = 0;
    int failCount = 0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_alu_src(id_alu_src), .id_branch(id_branch), .id_alu_op(id_alu_op),
        .flush_in(flush_in), .stall_out(stall_out), .ex_valid(ex_valid),
        .ex_alu_result(ex_alu_result), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] imm,
                                 input logic [4:0] rd, input logic [2:0] f3,
                                 input logic f7, input logic alusrc,
                                 input logic br, input logic [1:0] aluop);
        id_valid   = 1'b1;
        id_pc      = pc;
        id_rs1_val = rs1;
        id_rs2_val = rs2;
        id_imm     = imm;
        id_rd      = rd;
        id_funct3  = f3;
        id_funct7  = f7;
        id_alu_src = alusrc;
        id_branch  = br;
        id_alu_op  = aluop;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issues one register-register shift and waits (bounded) for its result.
    task automatic runShift(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f3, input logic f7, input logic [31:0] expResult);
        int cycles;
        int stalls;
        int expLat;
        int expStalls;
        expStalls = (SERIAL && (b[4:0] != 5'd0)) ? int'(b[4:0]) : 0;
        expLat    = expStalls + 1;
        applyStimulus(32'h0, a, b, 32'h0, 5'd9, f3, f7, 1'b0, 1'b0, 2'b10);
        tick();
        id_valid = 1'b0;
        cycles = 1;
        stalls = 0;
        while (ex_valid !== 1'b1 && cycles < 40) begin
            if (stall_out === 1'b1) stalls++;
            tick();
            cycles++;
        end
        checkOutput({tag, " valid"}, {31'b0, ex_valid}, 32'h1);
        checkOutput({tag, " result"}, ex_alu_result, expResult);
        checkOutput({tag, " latency"}, cycles, expLat);
        checkOutput({tag, " stalls"}, stalls, expStalls);
    endtask

    initial begin
        int sawValid;
        rst_n    = 1'b0;
        flush_in = 1'b0;
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        id_valid = 1'b0;
        tick();
        tick();
        checkOutput("reset ex_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("reset result", ex_alu_result, 32'h0);
        checkOutput("reset stall", {31'b0, stall_out}, 32'h0);
        checkOutput("reset target", ex_branch_target, 32'h0);
        rst_n = 1'b1;
        tick();

        applyStimulus(32'h0, 32'd5, 32'd7, 32'h0, 5'd3, 3'b000, 1'b0, 1'b0, 1'b0, 2'b10);
        tick();
        id_valid = 1'b0;
        checkOutput("add valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("add result", ex_alu_result, 32'd12);
        checkOutput("add rd", {27'b0, ex_rd}, 32'd3);
        checkOutput("add rs2", ex_rs2_val, 32'd7);
        checkOutput("add taken", {31'b0, ex_branch_taken}, 32'h0);

        applyStimulus(32'h0, 32'd3, 32'd5, 32'h0, 5'd4, 3'b000, 1'b1, 1'b0, 1'b0, 2'b10);
        tick();
        checkOutput("sub reg", ex_alu_result, 32'hFFFFFFFE);
        applyStimulus(32'h0, 32'd3, 32'd0, 32'd5, 5'd4, 3'b000, 1'b1, 1'b1, 1'b0, 2'b10);
        tick();
        id_valid = 1'b0;
        checkOutput("addi f7", ex_alu_result, 32'd8);
        tick();
        checkOutput("bubble valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("bubble hold", ex_alu_result, 32'd8);

        applyStimulus(32'h0, 32'd10, 32'd0, 32'd3, 5'd1, 3'b111, 1'b1, 1'b1, 1'b0, 2'b00);
        tick();
        checkOutput("op00 add", ex_alu_result, 32'd13);
        applyStimulus(32'h0, 32'd10, 32'd3, 32'd0, 5'd1, 3'b000, 1'b0, 1'b0, 1'b0, 2'b01);
        tick();
        checkOutput("op01 sub", ex_alu_result, 32'd7);
        applyStimulus(32'h0, 32'd10, 32'd3, 32'hDEADBEEF, 5'd1, 3'b000, 1'b0, 1'b1, 1'b0, 2'b11);
        tick();
        checkOutput("op11 passb", ex_alu_result, 32'hDEADBEEF);
        applyStimulus(32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd1, 3'b010, 1'b0, 1'b0, 1'b0, 2'b10);
        tick();
        checkOutput("slt", ex_alu_result, 32'h1);
        applyStimulus(32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd1, 3'b011, 1'b0, 1'b0, 1'b0, 2'b10);
        tick();
        checkOutput("sltu", ex_alu_result, 32'h0);
        applyStimulus(32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd1, 3'b100, 1'b0, 1'b0, 1'b0, 2'b10);
        tick();
        checkOutput("xor", ex_alu_result, 32'h0FF00FF0);
        applyStimulus(32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd1, 3'b110, 1'b0, 1'b0, 1'b0, 2'b10);
        tick();
        checkOutput("or", ex_alu_result, 32'hFFF0FFF0);
        applyStimulus(32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd1, 3'b111, 1'b0, 1'b0, 1'b0, 2'b10);
        tick();
        id_valid = 1'b0;
        checkOutput("and", ex_alu_result, 32'hF000F000);

        runShift("sra4", 32'h80000000, 32'd4, 3'b101, 1'b1, 32'hF8000000);
        runShift("srl4", 32'h80000000, 32'd4, 3'b101, 1'b0, 32'h08000000);
        runShift("sll33", 32'h00000001, 32'd33, 3'b001, 1'b0, 32'h00000002);
        runShift("sll0", 32'h12345678, 32'd32, 3'b001, 1'b0, 32'h12345678);

        applyStimulus(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0, 3'b100, 1'b0, 1'b0, 1'b1, 2'b01);
        tick();
        checkOutput("blt taken", {31'b0, ex_branch_taken}, 32'h1);
        checkOutput("blt target", ex_branch_target, 32'h120);
        applyStimulus(32'h100, 32'd5, 32'd6, 32'h40, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b01);
        tick();
        checkOutput("beq not taken", {31'b0, ex_branch_taken}, 32'h0);
        checkOutput("beq target", ex_branch_target, 32'h140);
        applyStimulus(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0, 3'b111, 1'b0, 1'b0, 1'b1, 2'b01);
        tick();
        checkOutput("bgeu taken", {31'b0, ex_branch_taken}, 32'h1);

        applyStimulus(32'h0, 32'd1, 32'd1, 32'h0, 5'd7, 3'b000, 1'b0, 1'b0, 1'b0, 2'b10);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        id_valid = 1'b0;
        checkOutput("flush valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("flush taken", {31'b0, ex_branch_taken}, 32'h0);
        checkOutput("flush target hold", ex_branch_target, 32'h120);

`ifdef SERIAL_SHIFT_EN
        applyStimulus(32'h0, 32'd1, 32'd10, 32'h0, 5'd2, 3'b001, 1'b0, 1'b0, 1'b0, 2'b10);
        tick();
        id_valid = 1'b0;
        checkOutput("shift stall c1", {31'b0, stall_out}, 32'h1);
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        checkOutput("shift flush stall", {31'b0, stall_out}, 32'h0);
        checkOutput("shift flush valid", {31'b0, ex_valid}, 32'h0);
        sawValid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ex_valid !== 1'b0) sawValid++;
        end
        checkOutput("shift flush no result", sawValid, 0);
`endif

        applyStimulus(32'h0, 32'h80000000, 32'd10, 32'h0, 5'd5, 3'b101, 1'b1, 1'b0, 1'b0, 2'b10);
        tick();
        id_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("async rst result", ex_alu_result, 32'h0);
        checkOutput("async rst rd", {27'b0, ex_rd}, 32'h0);
        checkOutput("async rst rs2", ex_rs2_val, 32'h0);
        checkOutput("async rst stall", {31'b0, stall_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ex_valid !== 1'b0) sawValid++;
        end
        checkOutput("post rst no result", sawValid, 0);
        checkOutput("post rst stall", {31'b0, stall_out}, 32'h0);

        applyStimulus(32'h0, 32'd20, 32'd22, 32'h0, 5'd6, 3'b000, 1'b0, 1'b0, 1'b0, 2'b10);
        tick();
        id_valid = 1'b0;
        checkOutput("post rst add", ex_alu_result, 32'd42);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have `rst_n`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have `id_valid`, input, 1 bit: ID/EX register holds a live instruction.
REQ-004 SHALL have `id_pc`, `id_rs1_val`, `id_rs2_val`, `id_imm`, inputs, 32 bits each: operands from ID/EX.
REQ-005 SHALL have `id_rd` (5), `id_funct3` (3) and `id_funct7` (1, instr bit 30), inputs.
REQ-006 SHALL have `id_alu_src` (1), `id_branch` (1) and `id_alu_op` (2), inputs: control from ID/EX.
REQ-007 SHALL have `flush_in`, input, 1 bit: kill the current and in-progress instruction.
REQ-008 SHALL have `stall_out`, output, 1 bit: ID/EX must hold its contents.
REQ-009 SHALL have `ex_valid`, output, 1 bit: EX/MEM outputs are live.
REQ-010 SHALL have `ex_alu_result` (32), `ex_rs2_val` (32) and `ex_rd` (5), registered outputs.
REQ-011 SHALL have `ex_branch_taken` (1) and `ex_branch_target` (32), registered outputs.

Function
REQ-012 SHALL use operand A = `id_rs1_val`; operand B = `id_imm` when `id_alu_src`=1, else `id_rs2_val`.
REQ-013 SHALL decode `id_alu_op` as: 00 ADD; 01 SUB; 11 pass B; 10 select by funct3.
REQ-014 SHALL decode funct3 for `id_alu_op`=10 as:
- 000: ADD, or SUB only when funct7=1 and alu_src=0.
- 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
- 101: SRL, or SRA when funct7=1.
- 110: OR. 111: AND.
REQ-015 SHALL take the shift amount as B[4:0] and discard upper bits; SLT/SLTU SHALL return 32'h0/32'h1.
REQ-016 SHALL resolve branches when `id_branch`=1, by funct3:
- 000 EQ; 001 NE; 100 LT signed; 101 GE signed; 110 LTU; 111 GEU.
- 010/011: never taken.
REQ-017 SHALL compute target = `id_pc` + `id_imm`, modulo 2^32; `ex_branch_taken` is 0 when `id_branch`=0.
REQ-018 SHALL have non-shift latency of 1 cycle: accepted at edge N, outputs valid after edge N+1, `stall_out`=0.
REQ-019 SHALL accept an instruction when `id_valid`=1, `stall_out`=0 and `flush_in`=0.
REQ-020 SHALL drive `ex_valid`=0 after any edge with no completing instruction; data outputs then hold their previous value.
REQ-021 SHALL, when `flush_in`=1 with `id_valid`=1, discard the input; next `ex_valid`=0 and `ex_branch_taken`=0.
REQ-022 SHALL register `ex_rs2_val` = `id_rs2_val` and `ex_rd` = `id_rd` unchanged.

Reset
REQ-023 SHALL, while `rst_n`=0, immediately force all of the following to 0:
- every output;
- FSM state = IDLE;
- shift counter.
REQ-024 SHALL abandon an in-progress shift on reset; no result is produced after release.

Configuration
REQ-025 SHALL, with `SERIAL_SHIFT_EN` defined, run SLL/SRL/SRA iteratively, 1 bit per cycle, using FSM IDLE/SHIFT.
REQ-026 SHALL, for shamt=0, complete a serial shift in 1 cycle like other ops.
REQ-027 SHALL, for shamt=N>0, load the operand and count at acceptance and go IDLE->SHIFT.
REQ-028 SHALL, in SHIFT, shift once per edge and return to IDLE with the result registered, `ex_valid`=1, when the count reaches 0.
REQ-029 SHALL give a serial shift with shamt=N>0 a total latency of N+1 edges.
REQ-030 SHALL hold `stall_out`=1 combinationally in SHIFT until the final shift edge completes; `ex_valid`=0 meanwhile.
REQ-031 SHALL, on `flush_in`=1 in SHIFT, go SHIFT->IDLE at the next edge with no result and `stall_out` deasserted.
REQ-032 SHALL, without `SERIAL_SHIFT_EN`, use a single-cycle barrel shift; `stall_out` is tied 0 and there is no FSM.

Verification
REQ-033 SHALL cover ALU ops: ADD rs1=5, rs2=7, alu_op=10, f3=000 -> `ex_alu_result`=12, `ex_valid`=1 one cycle later.
REQ-034 SHALL cover SUB: rs1=3, rs2=5, f7=1, alu_src=0 -> 0xFFFFFFFE; same with alu_src=1, imm=5 -> 8.
REQ-035 SHALL cover branches: BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> taken=1, target=0x120; BGEU same operands -> taken=1.
REQ-036 SHALL cover serial shift (macro on): SRA 0x80000000 by 4 -> stall 4 cycles, result 0xF8000000 at edge 5; macro off -> same result at edge 1, no stall.
REQ-037 SHALL cover flush: `flush_in` at SHIFT cycle 2 of shamt=10 -> `ex_valid` never 1, `stall_out`=0 next cycle; flush with `id_valid` -> bubble.
REQ-038 SHALL cover reset: `rst_n` low mid-shift (async, between edges) -> all outputs 0 immediately, IDLE after release.
